// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module   : mem_bus_ctrl
// Purpose  : Data-memory access sequencer between the MEM stage and the
//            external request/acknowledge data bus. Optional transaction
//            timeout is enabled by defining MEMCTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_sel_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        bus_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_sel_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_busy = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("mem_bus_ctrl: TIMEOUT out of range 1..65535");
   end

   logic [1:0]  state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        bus_err_q, bus_err_d;
   logic        abort_q, abort_d;

   logic w_start;
   logic w_ack;
   logic w_expire;

   assign w_start = (state_q == c_idle) && mem_req_i && !flush_i;
   // Ack is only meaningful while the request is actually on the bus.
   assign w_ack   = (state_q == c_busy) && bus_req_q && bus_ack_i;

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int            CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (w_start) begin
         cnt_d = '0;
      end else if ((state_q == c_busy) && !w_ack) begin
         cnt_d = cnt_q + c_cnt_one;
      end
   end

   // Expiry fires on the edge where the counter would reach TIMEOUT.
   assign w_expire = (state_q == c_busy) && !w_ack && (cnt_q == c_cnt_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      bus_sel_d     = bus_sel_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      bus_err_d     = 1'b0;
      abort_d       = abort_q;

      case (state_q)
         c_idle: begin
            if (w_start) begin
               state_d     = c_busy;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we_i;
               bus_addr_d  = mem_addr_i;
               bus_wdata_d = mem_wdata_i;
               bus_sel_d   = mem_sel_i;
               abort_d     = 1'b0;
            end
         end
         c_busy: begin
            if (flush_i) begin
               abort_d = 1'b1;
            end
            if (w_ack) begin
               state_d   = c_done;
               bus_req_d = 1'b0;
               // A flushed load must not disturb previously returned data.
               if (!bus_we_q && !abort_q && !flush_i) begin
                  rdata_d       = bus_rdata_i;
                  rdata_valid_d = 1'b1;
               end
            end else if (w_expire) begin
               state_d   = c_done;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
            end
         end
         c_done: begin
            state_d = c_idle;
         end
         default: begin
            state_d   = c_idle;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= c_idle;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         bus_sel_q     <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         bus_err_q     <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         bus_sel_q     <= bus_sel_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         bus_err_q     <= bus_err_d;
         abort_q       <= abort_d;
      end
   end

   assign stall_o       = w_start || (state_q == c_busy);
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_valid_q;
   assign bus_err_o     = bus_err_q;
   assign bus_req_o     = bus_req_q;
   assign bus_we_o      = bus_we_q;
   assign bus_addr_o    = bus_addr_q;
   assign bus_wdata_o   = bus_wdata_q;
   assign bus_sel_o     = bus_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// Module   : tb_mem_bus_ctrl
// Purpose  : Self-checking bench for mem_bus_ctrl with a transaction-level
//            reference model (stall length, returned data, pulses).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_i, mem_we_i, flush_i, bus_ack_i;
   logic [31:0] mem_addr_i, mem_wdata_i, bus_rdata_i;
   logic [3:0]  mem_sel_i;
   logic        stall_o, rdata_valid_o, bus_err_o, bus_req_o, bus_we_o;
   logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_sel_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model_rdata;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req_i    (mem_req_i),
      .mem_we_i     (mem_we_i),
      .mem_addr_i   (mem_addr_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_sel_i    (mem_sel_i),
      .flush_i      (flush_i),
      .stall_o      (stall_o),
      .rdata_o      (rdata_o),
      .rdata_valid_o(rdata_valid_o),
      .bus_err_o    (bus_err_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_sel_o    (bus_sel_o),
      .bus_ack_i    (bus_ack_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   // One access from request to DONE. ack_at = 0 means the bus never acks;
   // flush_at = 0 means no flush during BUSY.
   task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int ack_at, input int flush_at, input logic [31:0] rd);
      bit timed_out, aborted, exp_valid;
      int busy_len, stall_cnt;
      timed_out = (ack_at == 0);
      busy_len  = timed_out ? TB_TIMEOUT : ack_at;
      aborted   = (flush_at >= 1) && (flush_at <= busy_len);
      exp_valid = !we && !aborted && !timed_out;
      stall_cnt = 0;

      @(posedge clk); #1;
      mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
      mem_sel_i = sel; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
      #3;
      n_checks++;
      if (bus_req_o !== 1'b0) $display("FAIL %s req_cycle_bus_req: got %b want 0", tag, bus_req_o);
      else n_pass++;
      stall_cnt += int'(stall_o === 1'b1);

      for (int j = 1; j <= busy_len; j++) begin
         @(posedge clk); #1;
         mem_addr_i  = $urandom; mem_wdata_i = $urandom;
         mem_we_i    = 1'($urandom); mem_sel_i = 4'($urandom);
         flush_i     = (j == flush_at);
         bus_ack_i   = (j == ack_at);
         bus_rdata_i = (j == ack_at) ? rd : $urandom;
         #3;
         stall_cnt += int'(stall_o === 1'b1);
         n_checks++;
         if (bus_req_o !== 1'b1 || bus_we_o !== we || bus_addr_o !== addr ||
             bus_wdata_o !== wdata || bus_sel_o !== sel)
            $display("FAIL %s busy%0d_bus_fields: got req=%b we=%b a=%h d=%h s=%h want req=1 we=%b a=%h d=%h s=%h",
                     tag, j, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
                     we, addr, wdata, sel);
         else n_pass++;
         n_checks++;
         if (rdata_valid_o !== 1'b0 || bus_err_o !== 1'b0)
            $display("FAIL %s busy%0d_pulses: got valid=%b err=%b want 0 0", tag, j, rdata_valid_o, bus_err_o);
         else n_pass++;
      end

      @(posedge clk); #1;
      flush_i = 1'b0; bus_ack_i = 1'b0; mem_we_i = we; mem_addr_i = addr;
      mem_wdata_i = wdata; mem_sel_i = sel;
      #3;
      if (exp_valid) model_rdata = rd;
      n_checks++;
      if (stall_o !== 1'b0 || bus_req_o !== 1'b0)
         $display("FAIL %s done_release: got stall=%b req=%b want 0 0", tag, stall_o, bus_req_o);
      else n_pass++;
      n_checks++;
      if (rdata_valid_o !== exp_valid || bus_err_o !== timed_out)
         $display("FAIL %s done_pulses: got valid=%b err=%b want %b %b", tag,
                  rdata_valid_o, bus_err_o, exp_valid, timed_out);
      else n_pass++;
      n_checks++;
      if (rdata_o !== model_rdata)
         $display("FAIL %s done_rdata: got %h want %h", tag, rdata_o, model_rdata);
      else n_pass++;
      n_checks++;
      if (stall_cnt != busy_len + 1)
         $display("FAIL %s stall_len: got %0d want %0d", tag, stall_cnt, busy_len + 1);
      else n_pass++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_req_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0;
         #3;
         n_checks++;
         if (stall_o !== 1'b0 || bus_req_o !== 1'b0 || rdata_valid_o !== 1'b0 || bus_err_o !== 1'b0)
            $display("FAIL idle: got stall=%b req=%b valid=%b err=%b want 0 0 0 0",
                     stall_o, bus_req_o, rdata_valid_o, bus_err_o);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
      mem_sel_i = '0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
      model_rdata = '0;
      repeat (2) @(posedge clk);
      #4;
      n_checks++;
      if ({stall_o, rdata_valid_o, bus_err_o, bus_req_o, bus_we_o} !== 5'b0 ||
          rdata_o !== 32'h0 || bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_sel_o !== 4'h0)
         $display("FAIL reset_values: got ctl=%b rdata=%h addr=%h wdata=%h sel=%h want all zero",
                  {stall_o, rdata_valid_o, bus_err_o, bus_req_o, bus_we_o},
                  rdata_o, bus_addr_o, bus_wdata_o, bus_sel_o);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_txn("load_ack3", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 0, 32'hDEAD_BEEF);
      idle_cycles(1);
      run_txn("store_ack1", 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 1, 0, 32'hFFFF_FFFF);
      idle_cycles(1);
   endtask

   task automatic test_back_to_back();
      run_txn("b2b_first", 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 0, 32'hA5A5_0001);
      run_txn("b2b_second", 1'b0, 32'h0000_0204, 32'h0, 4'hF, 1, 0, 32'h5A5A_0002);
      idle_cycles(1);
   endtask

   task automatic test_flush();
      run_txn("flush_busy", 1'b0, 32'h0000_0300, 32'h0, 4'hF, 4, 2, 32'hBAD0_BAD0);
      idle_cycles(1);
      @(posedge clk); #1;
      mem_req_i = 1'b1; flush_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400;
      #3;
      n_checks++;
      if (stall_o !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall_o);
      else n_pass++;
      idle_cycles(2);
   endtask

   task automatic test_timeout();
`ifdef MEMCTRL_TIMEOUT_EN
      run_txn("timeout", 1'b0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 32'h0);
      idle_cycles(1);
      run_txn("ack_at_expiry", 1'b0, 32'h0000_0504, 32'h0, 4'hF, TB_TIMEOUT, 0, 32'h0BAD_F00D);
      idle_cycles(1);
`else
      run_txn("long_wait", 1'b0, 32'h0000_0500, 32'h0, 4'hF, TB_TIMEOUT + 6, 0, 32'h0BAD_F00D);
      idle_cycles(1);
`endif
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h600; mem_wdata_i = 32'hCAFE_0000;
      mem_sel_i = 4'hF; flush_i = 1'b0; bus_ack_i = 1'b0;
      @(posedge clk); #1;
      #5;
      rst = 1'b1; mem_req_i = 1'b0;
      #1;
      model_rdata = '0;
      n_checks++;
      if ({stall_o, rdata_valid_o, bus_err_o, bus_req_o, bus_we_o} !== 5'b0 ||
          rdata_o !== 32'h0 || bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_sel_o !== 4'h0)
         $display("FAIL reset_mid: got ctl=%b rdata=%h addr=%h wdata=%h sel=%h want all zero",
                  {stall_o, rdata_valid_o, bus_err_o, bus_req_o, bus_we_o},
                  rdata_o, bus_addr_o, bus_wdata_o, bus_sel_o);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn("after_reset", 1'b0, 32'h0000_0700, 32'h0, 4'h3, 2, 0, 32'h7777_1234);
      idle_cycles(1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         logic        we;
         logic [31:0] addr, wdata, rd;
         logic [3:0]  sel;
         int          ack_at, flush_at;
         we       = 1'($urandom);
         addr     = $urandom; wdata = $urandom; rd = $urandom;
         sel      = 4'($urandom);
         ack_at   = $urandom_range(1, TB_TIMEOUT);
         flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         run_txn("random", we, addr, wdata, sel, ack_at, flush_at, rd);
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
      end
      idle_cycles(1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Data-memory access sequencer between the MEM stage and the external data bus. Accepts one load/store per instruction from MEM and runs it as a multi-cycle request/acknowledge transaction. Holds the pipeline via `stall_o` until the bus completes, then returns read data for write-back. Sits beside the MEM stage; `stall_o` feeds the pipeline stall controller.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum BUSY cycles before a bus transaction is abandoned (range 1..65535).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high (`RstEnable` = 1'b1).
- `mem_req_i`  in  1  MEM stage holds a load/store this cycle.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  store data.
- `mem_sel_i`  in  4  byte-lane enables.
- `flush_i`  in  1  pipeline flush (exception); cancels the current access.
- `stall_o`  out  1  pipeline hold request.
- `rdata_o`  out  32  captured load data.
- `rdata_valid_o`  out  1  one-cycle pulse: `rdata_o` holds a completed load.
- `bus_err_o`  out  1  one-cycle pulse: transaction timed out.
- `bus_req_o`  out  1  bus request; held until ack.
- `bus_we_o`  out  1  bus write enable.
- `bus_addr_o`  out  32  bus address.
- `bus_wdata_o`  out  32  bus write data.
- `bus_sel_o`  out  4  bus byte lanes.
- `bus_ack_i`  in  1  bus completion; sampled only while `bus_req_o` = 1.
- `bus_rdata_i`  in  32  read data, valid with `bus_ack_i`.

## Operation

- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - If `mem_req_i` = 1 and `flush_i` = 0, latch we/addr/wdata/sel into bus registers, clear the abort flag, clear the timeout counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold `bus_req_o` = 1 with latched bus fields stable.
  - On `bus_ack_i` = 1: capture `bus_rdata_i` into `rdata_o` (loads only), drop `bus_req_o`, go to DONE.
  - `flush_i` = 1 in BUSY sets the abort flag. The transaction is not cut short; it runs to ack or timeout.
- DONE, lasting one cycle:
  - `rdata_valid_o` = 1 iff load, not aborted, and not timed out.
  - Always go to IDLE. A request present in DONE is the completed instruction advancing and is not restarted.
- `stall_o` is combinational: 1 when (IDLE and `mem_req_i` and not `flush_i`) or BUSY; 0 in DONE.
- A timed-out or aborted load leaves `rdata_o` unchanged.

## Timing

- Reset values:
  - State IDLE.
  - `rdata_o`, `bus_addr_o`, and `bus_wdata_o` = 0.
  - `bus_sel_o` = 0.
  - `bus_req_o`, `bus_we_o`, `rdata_valid_o`, `bus_err_o`, and the abort flag = 0.
  - Timeout counter = 0.
- `rst` asserted mid-transaction drops `bus_req_o` immediately (asynchronous). The bus owner must tolerate an abandoned request.
- Request seen in cycle 0 → `bus_req_o` = 1 from cycle 1.
- Ack in cycle k (k ≥ 1) → DONE in cycle k+1.
- `stall_o` is high in cycles 0..k and low in cycle k+1. Minimum stall is 2 cycles.
- Back-to-back accesses: the next request is accepted in the cycle after DONE.
- `flush_i` in IDLE in the same cycle as `mem_req_i`: no transaction and no stall.

## Configuration

- Macro: `MEMCTRL_TIMEOUT_EN`.
- Defined:
  - Counter width is $clog2(TIMEOUT+1); it increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT with no ack, drop `bus_req_o`, pulse `bus_err_o` in DONE, and suppress `rdata_valid_o`.
  - Ack on the same edge as expiry wins: normal completion.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - `bus_err_o` is tied to 0.

## Test plan

- Load addr 0x0000_0100, ack on 3rd BUSY cycle with rdata 0xDEAD_BEEF → `stall_o` high 4 cycles; `rdata_o` = 0xDEAD_BEEF with one `rdata_valid_o` pulse in DONE.
- Store addr 0x10, wdata 0x1234_5678, sel 4'b0011, immediate ack → bus fields match; `bus_we_o` = 1; `rdata_valid_o` stays 0; 2-cycle stall.
- Two loads back-to-back, ack 1 cycle each → exactly one IDLE cycle between DONE and the second `bus_req_o`; each load pulses `rdata_valid_o` once.
- Load with `flush_i` pulsed in the 2nd BUSY cycle, ack in 4th → `bus_req_o` held until ack; no `rdata_valid_o`; `rdata_o` keeps its prior value.
- With `MEMCTRL_TIMEOUT_EN` and TIMEOUT = 4, no ack → `bus_req_o` drops after 4 BUSY cycles; `bus_err_o` pulses once; `stall_o` releases.
- `rst` asserted in BUSY → all outputs return to reset values in the same cycle; a subsequent request starts cleanly.
